// File: rtl/wb_bus_watchdog.sv
// wb_bus_watchdog: Wishbone timeout guard between a bus master and one
// interconnect port. Requests pass straight through. A beat left unanswered
// for TIMEOUT cycles is ended with err, and the slave side is then blanked
// for two cycles (ABORT, DRAIN) so the stalled slave sees its cycle end.
// TIMEOUT = 0 turns the block into a pure passthrough.
// Optional build macro WB_WDOG_STATUS_EN adds err_adr_o / err_cnt_o, which
// record the address of the last aborted beat and a saturating abort count.
module wb_bus_watchdog #(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   // master side
   input  logic [31:0] wbm_adr_i,
   input  logic [31:0] wbm_dat_i,
   input  logic [3:0]  wbm_sel_i,
   input  logic        wbm_we_i,
   input  logic        wbm_cyc_i,
   input  logic        wbm_stb_i,
   input  logic [2:0]  wbm_cti_i,
   input  logic [1:0]  wbm_bte_i,
   output logic [31:0] wbm_dat_o,
   output logic        wbm_ack_o,
   output logic        wbm_err_o,
   output logic        wbm_rty_o,
   // interconnect side
   output logic [31:0] wbs_adr_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  wbs_sel_o,
   output logic        wbs_we_o,
   output logic [2:0]  wbs_cti_o,
   output logic [1:0]  wbs_bte_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   input  logic [31:0] wbs_dat_i,
   input  logic        wbs_ack_i,
   input  logic        wbs_err_i,
   input  logic        wbs_rty_i,
   // status
   output logic        timeout_o
`ifdef WB_WDOG_STATUS_EN
   ,
   output logic [31:0] err_adr_o,
   output logic [15:0] err_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_FWD   = 2'd0,
      ST_ABORT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Watchdog is compiled out entirely when TIMEOUT is zero.
   localparam bit              WDOG_EN  = (TIMEOUT != 0);
   // Counter value seen on the last permitted wait cycle of a beat.
   localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             req, resp, abort_now;

   assign req  = wbm_cyc_i & wbm_stb_i;
   assign resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

   // Address, data and burst tags are never gated, only cyc/stb are.
   assign wbs_adr_o = wbm_adr_i;
   assign wbs_dat_o = wbm_dat_i;
   assign wbs_sel_o = wbm_sel_i;
   assign wbs_we_o  = wbm_we_i;
   assign wbs_cti_o = wbm_cti_i;
   assign wbs_bte_o = wbm_bte_i;
   assign wbm_dat_o = wbs_dat_i;
   assign timeout_o = timeout_q;

   // Next state, wait counter and gated bus controls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      abort_now = 1'b0;
      wbs_cyc_o = wbm_cyc_i;
      wbs_stb_o = wbm_stb_i;
      wbm_ack_o = wbs_ack_i;
      wbm_err_o = wbs_err_i;
      wbm_rty_o = wbs_rty_i;
      unique case (state_q)
         ST_FWD: begin
            if (req && !resp) begin
               // A response on the last wait cycle wins, so only an
               // unanswered last cycle triggers the abort.
               if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                  abort_now = 1'b1;
                  state_d   = ST_ABORT;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               // Response, dropped request or idle: next beat starts fresh.
               cnt_d = '0;
            end
         end
         ST_ABORT: begin
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_ack_o = 1'b0;
            wbm_err_o = 1'b1;
            wbm_rty_o = 1'b0;
            cnt_d     = '0;
            state_d   = ST_DRAIN;
         end
         ST_DRAIN: begin
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_ack_o = 1'b0;
            wbm_err_o = 1'b0;
            wbm_rty_o = 1'b0;
            cnt_d     = '0;
            state_d   = ST_FWD;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_FWD;
         end
      endcase
      timeout_d = (state_d == ST_ABORT);
   end

   // State, counter and timeout pulse registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= ST_FWD;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef WB_WDOG_STATUS_EN
   logic [31:0] err_adr_q, err_adr_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   // Capture the aborted address and bump the saturating abort count.
   always_comb begin
      err_adr_d = err_adr_q;
      err_cnt_d = err_cnt_q;
      if (abort_now) begin
         err_adr_d = wbm_adr_i;
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end
   end

   // Status capture registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         err_adr_q <= '0;
         err_cnt_q <= '0;
      end else begin
         err_adr_q <= err_adr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_adr_o = err_adr_q;
   assign err_cnt_o = err_cnt_q;
`endif

endmodule
